div_xxbit_shift: RTL

- Iterative shift-subtract (restoring) divider: the inverse of the shift-add multiplier in the common arithmetic library.
- Divides an unsigned DATA_WIDTH-bit dividend by an unsigned DATA_WIDTH-bit divisor and produces a quotient and a remainder.
- Resolves one quotient bit per clock.
- Sits in the common arithmetic library beside the multiplier and is intended for the execute stage's multi-cycle unit.

---
 rtl/div_xxbit_shift.sv | 120 ++++++++++++
 1 files changed

// File: rtl/div_xxbit_shift.sv
// Iterative restoring shift-subtract divider, one quotient bit per clock.
// Define DIV_XXBIT_SHIFT_SIGNED_EN for two's-complement operands; the default build is unsigned.
module div_xxbit_shift #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  output logic                  o_busy,
  output logic                  o_end,
  output logic [DATA_WIDTH-1:0] o_quo,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_div_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [2*W-1:0]  work, work_step;
  logic [W-1:0]    divisor;
  logic [CW-1:0]   count;
  logic [W:0]      trial;
  logic            accept, last_step, b_zero;
  logic [W-1:0]    a_mag, b_mag;
  logic [W-1:0]    quo_res, rem_res;

  assign accept    = (state == IDLE) && i_start;
  assign last_step = (state == CALC) && (count == CW'(1));
  assign b_zero    = (i_num_b == '0);

`ifdef DIV_XXBIT_SHIFT_SIGNED_EN
  logic neg_quo, neg_rem;

  assign a_mag   = i_num_a[W-1] ? -i_num_a : i_num_a;
  assign b_mag   = i_num_b[W-1] ? -i_num_b : i_num_b;
  // Most-negative / -1 falls out naturally: the magnitude quotient wraps to itself.
  assign quo_res = neg_quo ? -work_step[W-1:0]   : work_step[W-1:0];
  assign rem_res = neg_rem ? -work_step[2*W-1:W] : work_step[2*W-1:W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      neg_quo <= i_num_a[W-1] ^ i_num_b[W-1];
      neg_rem <= i_num_a[W-1];
    end
  end
`else
  assign a_mag   = i_num_a;
  assign b_mag   = i_num_b;
  assign quo_res = work_step[W-1:0];
  assign rem_res = work_step[2*W-1:W];
`endif

  // Trial uses the bit shifted out of the upper half, so it needs W+1 bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    trial     = work[2*W-1:W-1] - {1'b0, divisor};
    work_step = {work[2*W-2:0], 1'b0};
    if (!trial[W]) begin
      work_step[2*W-1:W] = trial[W-1:0];
      work_step[0]       = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_start) state_next = b_zero ? DONE : CALC;
      CALC: if (count == CW'(1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: datapath registers are reset too, so outputs read zero after reset and no stale partial survives.
    if (i_rst) begin
      work       <= '0;
      divisor    <= '0;
      count      <= '0;
      o_quo      <= '0;
      o_rem      <= '0;
      o_div_zero <= 1'b0;
    end else if (accept) begin
      work    <= {{W{1'b0}}, a_mag};
      divisor <= b_mag;
      count   <= CW'(W);
      if (b_zero) begin
        o_quo      <= '1;
        o_rem      <= i_num_a;
        o_div_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      work  <= work_step;
      count <= count - CW'(1);
      if (last_step) begin
        o_quo      <= quo_res;
        o_rem      <= rem_res;
        o_div_zero <= 1'b0;
      end
    end
  end

  assign o_busy = (state != IDLE);
  assign o_end  = (state == DONE);

endmodule
